// File: rtl/scr1_ialu_rvm_pkg.sv
// Shared types for the iterative RISC-V M-extension unit: command encoding,
// FSM states and per-command operand signedness.
package scr1_ialu_rvm_pkg;

    typedef enum logic [2:0] {
        RVM_MUL    = 3'd0,
        RVM_MULH   = 3'd1,
        RVM_MULHSU = 3'd2,
        RVM_MULHU  = 3'd3,
        RVM_DIV    = 3'd4,
        RVM_DIVU   = 3'd5,
        RVM_REM    = 3'd6,
        RVM_REMU   = 3'd7
    } type_scr1_ialu_rvm_cmd_e;

    typedef enum logic [1:0] {
        RVM_ST_IDLE,
        RVM_ST_CALC,
        RVM_ST_CORR,
        RVM_ST_DONE
    } type_scr1_ialu_rvm_state_e;

    // {op1 signed, op2 signed}
    function automatic logic [1:0] rvm_op_signed(input type_scr1_ialu_rvm_cmd_e cmd);
        case (cmd)
            RVM_MUL, RVM_MULH, RVM_DIV, RVM_REM: rvm_op_signed = 2'b11;
            RVM_MULHSU:                          rvm_op_signed = 2'b10;
            default:                             rvm_op_signed = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/scr1_ialu_rvm_addsub.sv
// Combinational XLEN+1 adder/subtractor shared by the divide step and the
// sign-correction negation.
module scr1_ialu_rvm_addsub #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0] a,
    input  logic [XLEN:0] b,
    input  logic          sub,
    output logic [XLEN:0] res
);

    assign res = sub ? (a - b) : (a + b);

endmodule

// File: rtl/scr1_ialu_rvm_iter.sv
// Iterative MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU unit: shift-add multiply
// with configurable radix, restoring divide, fast path for divide special cases.
module scr1_ialu_rvm_iter
    import scr1_ialu_rvm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exu2ialu_rvm_cmd_vd_i,
    input  logic [2:0]      exu2ialu_rvm_cmd_i,
    input  logic [XLEN-1:0] exu2ialu_rvm_op1_i,
    input  logic [XLEN-1:0] exu2ialu_rvm_op2_i,
    input  logic            exu2ialu_rvm_kill_i,
    output logic            ialu2exu_rvm_res_rdy_o,
    output logic [XLEN-1:0] ialu2exu_rvm_res_o,
    output logic            ialu2exu_rvm_busy_o
);

    localparam int N_MUL = XLEN / MUL_BITS;
    localparam int N_DIV = XLEN;
    localparam int CNT_W = $clog2(XLEN + 1);

    type_scr1_ialu_rvm_state_e state, state_next;

    logic [2:0]        cmd;
    logic [XLEN-1:0]   opb;
    logic [2*XLEN-1:0] acc;
    logic              neg;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_last;
    logic [XLEN-1:0]   res_q;

    // Accept-time decode of the incoming command
    logic [1:0]      sgn;
    logic            op1_neg, op2_neg, in_div, in_rem, div_zero, div_ovf, fast;
    logic [XLEN-1:0] op1_mag, op2_mag, fast_res;

    assign sgn      = rvm_op_signed(type_scr1_ialu_rvm_cmd_e'(exu2ialu_rvm_cmd_i));
    assign op1_neg  = sgn[1] & exu2ialu_rvm_op1_i[XLEN-1];
    assign op2_neg  = sgn[0] & exu2ialu_rvm_op2_i[XLEN-1];
    assign op1_mag  = op1_neg ? -exu2ialu_rvm_op1_i : exu2ialu_rvm_op1_i;
    assign op2_mag  = op2_neg ? -exu2ialu_rvm_op2_i : exu2ialu_rvm_op2_i;
    assign in_div   = exu2ialu_rvm_cmd_i[2];
    assign in_rem   = exu2ialu_rvm_cmd_i[2] & exu2ialu_rvm_cmd_i[1];
    assign div_zero = in_div & (exu2ialu_rvm_op2_i == '0);
    assign div_ovf  = in_div & sgn[1]
                    & (exu2ialu_rvm_op1_i == {1'b1, {(XLEN-1){1'b0}}})
                    & (&exu2ialu_rvm_op2_i);
    assign fast     = div_zero | div_ovf;
    assign fast_res = div_zero ? (in_rem ? exu2ialu_rvm_op1_i : '1)
                               : (in_rem ? '0 : exu2ialu_rvm_op1_i);

    // Multiply: MUL_BITS chained shift-add steps per cycle, {hi, multiplier} in acc
    logic [2*XLEN-1:0] mul_chain [0:MUL_BITS];
    assign mul_chain[0] = acc;
    for (genvar k = 0; k < MUL_BITS; k++) begin : g_mul
        logic [XLEN:0] psum;
        assign psum = {1'b0, mul_chain[k][2*XLEN-1:XLEN]}
                    + (mul_chain[k][0] ? {1'b0, opb} : '0);
        assign mul_chain[k+1] = {psum, mul_chain[k][XLEN-1:1]};
    end

    // Shared adder: divide trial subtraction in CALC, result negation in CORR
    logic          is_div, is_rem, mul_hi, sel_hi, lo_zero;
    logic [XLEN:0] add_a, add_b, add_res;
    logic          add_sub;
    logic [XLEN:0] div_shift;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   sel, corr_res;

    assign is_div    = cmd[2];
    assign is_rem    = cmd[2] & cmd[1];
    assign mul_hi    = ~cmd[2] & (|cmd[1:0]);
    assign sel_hi    = mul_hi | is_rem;
    assign sel       = sel_hi ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    assign lo_zero   = (acc[XLEN-1:0] == '0);
    assign div_shift = acc[2*XLEN-1:XLEN-1];

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b1;
        if (state == RVM_ST_CALC) begin
            add_a = div_shift;
            add_b = {1'b0, opb};
        end else if (mul_hi) begin
            // high half of -P: ~P_hi plus the carry out of negating P_lo
            add_a   = {1'b0, ~acc[2*XLEN-1:XLEN]};
            add_b   = {{XLEN{1'b0}}, lo_zero};
            add_sub = 1'b0;
        end else begin
            add_b = {1'b0, sel};
        end
    end

    scr1_ialu_rvm_addsub #(.XLEN(XLEN)) i_addsub (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .res (add_res)
    );

    assign div_next = {(add_res[XLEN] ? div_shift[XLEN-1:0] : add_res[XLEN-1:0]),
                       acc[XLEN-2:0], ~add_res[XLEN]};
    assign corr_res = neg ? add_res[XLEN-1:0] : sel;
    assign cnt_last = is_div ? CNT_W'(N_DIV - 1) : CNT_W'(N_MUL - 1);

    always_comb begin
        state_next = state;
        if (exu2ialu_rvm_kill_i) begin
            state_next = RVM_ST_IDLE;
        end else begin
            case (state)
                RVM_ST_IDLE: if (exu2ialu_rvm_cmd_vd_i)
                                 state_next = fast ? RVM_ST_DONE : RVM_ST_CALC;
                RVM_ST_CALC: if (cnt == cnt_last) state_next = RVM_ST_CORR;
                RVM_ST_CORR: state_next = RVM_ST_DONE;
                default:     state_next = RVM_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RVM_ST_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd                    <= '0;
            opb                    <= '0;
            acc                    <= '0;
            neg                    <= 1'b0;
            cnt                    <= '0;
            res_q                  <= '0;
            ialu2exu_rvm_res_rdy_o <= 1'b0;
            ialu2exu_rvm_res_o     <= '0;
        end else begin
            case (state)
                RVM_ST_IDLE: if (exu2ialu_rvm_cmd_vd_i && !exu2ialu_rvm_kill_i) begin
                    cmd   <= exu2ialu_rvm_cmd_i;
                    opb   <= op2_mag;
                    acc   <= {{XLEN{1'b0}}, op1_mag};
                    neg   <= in_rem ? op1_neg : (op1_neg ^ op2_neg);
                    cnt   <= '0;
                    res_q <= fast_res;
                end
                RVM_ST_CALC: begin
                    acc <= is_div ? div_next : mul_chain[MUL_BITS];
                    cnt <= cnt + 1'b1;
                end
                RVM_ST_CORR: res_q <= corr_res;
                default: ;
            endcase
            ialu2exu_rvm_res_rdy_o <= (state == RVM_ST_DONE) && !exu2ialu_rvm_kill_i;
            if ((state == RVM_ST_DONE) && !exu2ialu_rvm_kill_i)
                ialu2exu_rvm_res_o <= res_q;
        end
    end

    assign ialu2exu_rvm_busy_o = (state != RVM_ST_IDLE);

endmodule
